// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_pkg
// Purpose  : Baud codes and FSM state type shared by the UART TX scheduler.
// Revision : 1.0  initial release
// ============================================================================
package uart_tx_scheduler_pkg;

    localparam logic [1:0] BAUD_OFF    = 2'b00;
    localparam logic [1:0] BAUD_9600   = 2'b01;
    localparam logic [1:0] BAUD_57600  = 2'b10;
    localparam logic [1:0] BAUD_115200 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RECONF    = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first set req above last_grant.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic             valid_o,
    output logic [IW-1:0]    winner_o
);

    logic [IW-1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        w_idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = IW'((int'(last_i) + k) % N_REQ);
            if (req_i[w_idx]) begin
                valid_o  = 1'b1;
                winner_o = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Shares one UART transmitter among N_REQ byte requesters.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int          N_REQ   = 3,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   ack_o,
    output logic [N_REQ-1:0]   err_o,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_done_i,
    input  logic               cfg_wr_i,
    input  logic [1:0]         cfg_sel_i,
    output logic [1:0]         baudrate_sel_o,
    output logic               cfg_pending_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] win_q, win_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    baud_q, baud_d;
    logic [1:0]    shadow_q, shadow_d;
    logic          pend_q, pend_d;

    logic          w_valid;
    logic [IW-1:0] w_winner;
    logic [7:0]    w_byte;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req_i    (req_i),
        .last_i   (last_q),
        .valid_o  (w_valid),
        .winner_o (w_winner)
    );

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == IW'(i)) w_byte = req_data_i[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            last_q     <= IW'(N_REQ - 1);
            win_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            cnt_q      <= 16'd0;
            baud_q     <= BAUD_9600;
            shadow_q   <= BAUD_9600;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            win_q      <= win_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            cnt_q      <= cnt_d;
            baud_q     <= baud_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        win_d      = win_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        cnt_d      = cnt_q;
        baud_d     = baud_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        ack_o      = '0;
        err_o      = '0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q)                             state_d = ST_RECONF;
                else if (|req_i && baud_q != BAUD_OFF)  state_d = ST_GRANT;
            end
            ST_GRANT: begin
                // A requester that withdrew since IDLE leaves nothing to send.
                if (w_valid) begin
                    win_d      = w_winner;
                    tx_data_d  = w_byte;
                    tx_start_d = 1'b1;
                    cnt_d      = 16'd0;
                    state_d    = ST_WAIT_DONE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q + 16'd1;
                if (tx_done_i) begin
                    ack_o[win_q] = 1'b1;
                    last_d       = win_q;
                    state_d      = ST_IDLE;
                end else if (cnt_q == TIMEOUT) begin
                    err_o[win_q] = 1'b1;
                    last_d       = win_q;
                    state_d      = ST_IDLE;
                end
            end
            ST_RECONF: begin
                baud_d  = shadow_q;
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A write landing in RECONF re-arms the pending flag for the next pass.
        if (cfg_wr_i) begin
            shadow_d = cfg_sel_i;
            pend_d   = 1'b1;
        end
    end

    assign tx_start_o     = tx_start_q;
    assign tx_data_o      = tx_data_q;
    assign baudrate_sel_o = baud_q;
    assign cfg_pending_o  = pend_q;

endmodule
`default_nettype wire
